uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the counterpart of the team's uart_tx on the same serial link (8N1, LSB first, idle-high line).
- Oversamples the asynchronous serial line with the system clock, samples each bit at mid-bit, and presents a parallel byte with a one-cycle done pulse.
- Flags framing errors.
- Sits at the image-processing link input, feeding the pixel/byte buffer.

Parameters:
- DATA_WIDTH, 8, data bits per frame; also sets the baud divider width to DATA_WIDTH*2+1.

Ports:
- clk_i_rx  input  1  system clock, all logic on rising edge
- rsnt_i_rx  input  1  asynchronous active-low reset
- data_i_serial_rx  input  1  asynchronous serial line, idle high
- baud_div_i_rx  input  DATA_WIDTH*2+1  clocks per bit; must be at least 4
- data_o_rx  output  DATA_WIDTH  last correctly received byte
- active_o_rx  output  1  high while a frame is being received
- done_o_rx  output  1  one-cycle pulse when data_o_rx is updated
- frame_err_o_rx  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - data_o_rx = 0, active_o_rx = 0, done_o_rx = 0, frame_err_o_rx = 0, STATE = IDLE.
  - Counters = 0, shift register = 0.
  - Both synchronizer flops and the previous-sample flop = 1.
- Input synchronizer: data_i_serial_rx passes through 2 flops, giving rx_s. All decisions use rx_s; add 2 cycles of input latency.
- Divider latch: baud_div_i_rx is captured into an internal register at start detection. Changes mid-frame have no effect until the next frame.
- half = latched divider >> 1.
- States: IDLE, START, DATA, STOP (2-bit encoding).
- IDLE:
  - Start is detected on a falling edge of rx_s (previous sample 1, current 0). A line held low never re-triggers.
  - On detection: active_o_rx <= 1, baud_counter <= 0, bit_counter <= 0, go to START.
- START:
  - Count to half-1, then sample rx_s.
  - If 0: valid start; baud_counter <= 0, go to DATA.
  - If 1: glitch; active_o_rx <= 0, return to IDLE. No pulse on any output.
- DATA:
  - Count to divider-1, then sample rx_s and shift it in at the MSB (shift right), so the first bit ends in bit 0.
  - Increment bit_counter and clear baud_counter.
  - After the DATA_WIDTH-th sample, go to STOP.
- STOP:
  - Count to divider-1, then sample rx_s. In all cases active_o_rx <= 0 and go to IDLE.
  - If 1: data_o_rx <= shift register and done_o_rx = 1 for exactly one cycle.
  - If 0: frame_err_o_rx = 1 for one cycle and data_o_rx keeps its old value.
- Sample timing: the sample point for bit k (0 = start) is half + k*divider clocks after the detection cycle. done fires at the middle of the stop bit, so the next frame's start edge is never missed.
- Output hold: done_o_rx and frame_err_o_rx are never high together. Each is 0 in every cycle other than the single pulse cycle.
- Back-to-back frames: after returning to IDLE, a new falling edge is accepted on the very next cycle.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.
- Counter arithmetic: baud_counter and bit_counter are DATA_WIDTH*2+1 bits and never wrap, because the divider is at least 4. Divider values below 4 are unsupported and their behaviour is undefined.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit (start, data, stop) is decided by a 2-of-3 majority of rx_s at counts sample-1, sample, sample+1.
  - The decision, shift, and transition happen at sample+1, so every event shifts one cycle later.
  - The start glitch check uses the same vote.
- Undefined: a single sample at the nominal sample point, exactly as described above.

Test Plan:
- Byte 0xA5, divider 16, line driven by a reference transmitter → one done pulse, data_o_rx = 0xA5, frame_err 0, active high from detection until the stop-bit sample.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap, divider 16 → three done pulses with correct bytes in order and no missed start.
- Line low for 3 clocks, then high, divider 16 → no done, no frame_err, active_o_rx returns to 0 at the START sample.
- Frame 0x55 with the stop bit forced low, then line high → frame_err pulse, no done, data_o_rx keeps its previous value; a following 0x12 frame is received correctly.
- Reset asserted mid-DATA of 0xC3, released, then 0x81 sent → after release, all outputs at reset values; done pulses once with 0x81.
- With UART_RX_MAJORITY_VOTE_EN defined: 1-clock glitches injected at each nominal sample point of 0x96, divider 16 → data_o_rx = 0x96. Without the macro, the same stimulus → corrupted byte.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, done and framing-error pulses
// Optional: UART_RX_MAJORITY_VOTE_EN decides each bit by a 2-of-3 vote around the sample point.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i_rx,
    input  logic                    rsnt_i_rx,
    input  logic                    data_i_serial_rx,
    input  logic [DATA_WIDTH*2:0]   baud_div_i_rx,
    output logic [DATA_WIDTH-1:0]   data_o_rx,
    output logic                    active_o_rx,
    output logic                    done_o_rx,
    output logic                    frame_err_o_rx
);

    localparam int CW = DATA_WIDTH*2+1;

    // The vote needs one extra count after the nominal point; reloading the
    // counter with the same offset keeps the bit period at exactly divider clocks.
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] OFFSET = CW'(1);
`else
    localparam logic [CW-1:0] OFFSET = '0;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic                  sync1;
    logic                  rx_s;
    logic                  prev;
    logic [CW-1:0]         div_q;
    logic [CW-1:0]         baud_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         target;
    logic                  at_sample;
    logic                  bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic prev2;
    assign bit_val = (rx_s & prev) | (rx_s & prev2) | (prev & prev2);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        target = div_q - CW'(1);
        if (state == START) begin
            target = (div_q >> 1) - CW'(1);
        end
        at_sample = (baud_cnt == target + OFFSET);
    end

    always_ff @(posedge clk_i_rx or negedge rsnt_i_rx) begin
        if (!rsnt_i_rx) begin
            state          <= IDLE;
            sync1          <= 1'b1;
            rx_s           <= 1'b1;
            prev           <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            prev2          <= 1'b1;
`endif
            div_q          <= '0;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            data_o_rx      <= '0;
            active_o_rx    <= 1'b0;
            done_o_rx      <= 1'b0;
            frame_err_o_rx <= 1'b0;
        end else begin
            sync1          <= data_i_serial_rx;
            rx_s           <= sync1;
            prev           <= rx_s;
`ifdef UART_RX_MAJORITY_VOTE_EN
            prev2          <= prev;
`endif
            done_o_rx      <= 1'b0;
            frame_err_o_rx <= 1'b0;
            case (state)
                IDLE: begin
                    if (prev && !rx_s) begin
                        active_o_rx <= 1'b1;
                        baud_cnt    <= '0;
                        bit_cnt     <= '0;
                        div_q       <= baud_div_i_rx;
                        state       <= START;
                    end
                end
                START: begin
                    if (at_sample) begin
                        if (!bit_val) begin
                            baud_cnt <= OFFSET;
                            state    <= DATA;
                        end else begin
                            active_o_rx <= 1'b0;
                            state       <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        shift    <= {bit_val, shift[DATA_WIDTH-1:1]};
                        bit_cnt  <= bit_cnt + CW'(1);
                        baud_cnt <= OFFSET;
                        if (bit_cnt == CW'(DATA_WIDTH-1)) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        active_o_rx <= 1'b0;
                        state       <= IDLE;
                        if (bit_val) begin
                            data_o_rx <= shift;
                            done_o_rx <= 1'b1;
                        end else begin
                            frame_err_o_rx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx driven by a behavioural 8N1 transmitter
module tb_uart_rx;

    localparam int DW = 8;
    localparam int CW = DW*2+1;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line = 1'b1;
    logic [CW-1:0] div = CW'(16);
    logic [DW-1:0] data_o;
    logic          active;
    logic          done;
    logic          ferr;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk_i_rx         (clk),
        .rsnt_i_rx        (rst_n),
        .data_i_serial_rx (line),
        .baud_div_i_rx    (div),
        .data_o_rx        (data_o),
        .active_o_rx      (active),
        .done_o_rx        (done),
        .frame_err_o_rx   (ferr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           ev_q[$];
    int            len_q[$];
    logic [DW-1:0] last_good = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference transmitter plus expectation model: a frame occupies 10*d clocks,
    // a glitch inverts the line for the one clock at the middle of a data bit.
    task automatic send(input logic [DW-1:0] b, input int d, input bit stop_ok,
                        input logic [DW-1:0] glitch, input int abort_at);
        logic [DW+1:0] bits;
        logic [DW-1:0] got;
        int n;
        bits = {stop_ok, b, 1'b0};
        n = 0;
        if (abort_at < 0) begin
            got = (VOTE != 0) ? b : (b ^ glitch);
            len_q.push_back(d/2 + (DW+1)*d + VOTE);
            if (stop_ok) begin
                ev_q.push_back('{err: 1'b0, data: got});
                last_good = got;
            end else begin
                ev_q.push_back('{err: 1'b1, data: last_good});
            end
        end
        div = CW'(d);
        for (int k = 0; k < DW+2; k++) begin
            for (int c = 0; c < d; c++) begin
                if (abort_at >= 0 && n >= abort_at) begin
                    line = 1'b1;
                    return;
                end
                line = bits[k];
                if (k >= 1 && k <= DW && c == d/2 && glitch[k-1])
                    line = ~bits[k];
                if (n == 5)
                    div = CW'($urandom_range(4, 40));
                @(posedge clk);
                #1;
                n++;
            end
        end
        line = 1'b1;
    endtask

    ev_t           mon_e;
    int            run = 0;
    logic [DW-1:0] shown = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            run   = 0;
            shown = '0;
        end else begin
            if (done || ferr) begin
                check("done_ferr_exclusive", {31'd0, done & ferr}, 32'd0);
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b ferr=%0b expected none", done, ferr);
                end else begin
                    mon_e = ev_q.pop_front();
                    check("pulse_kind_ferr", {31'd0, ferr}, {31'd0, mon_e.err});
                    check("data_out", {24'd0, data_o}, {24'd0, mon_e.data});
                    shown = mon_e.data;
                end
            end else begin
                check("data_hold", {24'd0, data_o}, {24'd0, shown});
            end
            if (active) begin
                run++;
            end else if (run > 0) begin
                if (len_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_active: length %0d expected no frame", run);
                end else begin
                    check("active_len", run, len_q.pop_front());
                end
                run = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rb;
        int rd;
        bit rok;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        send(8'hA5, 16, 1'b1, 8'h00, -1);
        idle(5);

        send(8'h00, 16, 1'b1, 8'h00, -1);
        send(8'hFF, 16, 1'b1, 8'h00, -1);
        send(8'h3C, 16, 1'b1, 8'h00, -1);
        idle(5);

        div = CW'(16);
        len_q.push_back(8 + VOTE);
        line = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(30);

        send(8'h55, 16, 1'b0, 8'h00, -1);
        idle(3);
        send(8'h12, 16, 1'b1, 8'h00, -1);
        idle(5);

        send(8'hC3, 16, 1'b1, 8'h00, 60);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        last_good = '0;
        idle(3);
        check("rel_data", {24'd0, data_o}, 32'd0);
        check("rel_active", {31'd0, active}, 32'd0);
        check("rel_done", {31'd0, done}, 32'd0);
        check("rel_ferr", {31'd0, ferr}, 32'd0);
        send(8'h81, 16, 1'b1, 8'h00, -1);
        idle(5);

        send(8'h96, 16, 1'b1, 8'hFF, -1);
        idle(5);

        for (int i = 0; i < 10; i++) begin
            rb  = DW'($urandom);
            rd  = $urandom_range(4, 24);
            rok = ($urandom_range(0, 4) != 0);
            send(rb, rd, rok, 8'h00, -1);
            idle(rok ? $urandom_range(0, 2) : $urandom_range(2, 5));
        end
        idle(60);

        check("events_drained", ev_q.size(), 32'd0);
        check("frames_drained", len_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
